icosoc_mod_eventplay: RTL and testbench
=======================================

Name: icosoc_mod_eventplay

Overview:
Timestamped event player. It is the transmit-side counterpart of the trigger/event recorder. The CPU pushes 64-bit events {pattern, timestamp} over the icosoc ctrl bus into an internal FIFO. A free-running 48-bit counter drives each event's pattern onto the output pins when the counter reaches that event's timestamp. Sits on the icosoc bus as a peripheral module; pins are driven through registered outputs.

Parameters:
- IO_LENGTH, 16: output pin count (1..16); the pattern is taken from the low IO_LENGTH bits of event[63:48].
- DEPTH, 64: event FIFO depth in entries; power of two, 4..256.
- CLOCK_FREQ_HZ, 0: unused; kept for icosoc uniformity.

Ports:
- clk  in  1  sole clock
- reset  in  1  synchronous, active-high
- ctrl_wr  in  4  byte write strobes; any bit set = write request
- ctrl_rd  in  1  read request
- ctrl_addr  in  16  register byte address
- ctrl_wdat  in  32  write data
- ctrl_rdat  out  32  read data, valid while ctrl_done=1
- ctrl_done  out  1  one-cycle transaction acknowledge
- IO  out  IO_LENGTH  registered output pattern

Behaviour:
- Reset (clk edge with reset=1):
  - IO=0, ctrl_done=0, ctrl_rdat=0.
  - Counter=0, FIFO empty, pending event invalid, state IDLE.
  - All sticky flags and staging registers are cleared.
- Bus transactions:
  - A request is accepted only when ctrl_done=0.
  - ctrl_done=1 exactly one cycle after acceptance, then 0 for at least one cycle.
  - ctrl_rdat=0 whenever not acknowledging a read.
  - Unmapped addresses: ack, reads return 0, writes are ignored.
- Register map (32-bit words):
  - 0x00 R: current IO. W: IO<=wdat[IO_LENGTH-1:0], effective only when run=0; ignored when run=1.
  - 0x04 STATUS R/W:
    - bit0 run (RW).
    - bit1 late (sticky, W1C).
    - bit2 overflow (sticky, W1C).
    - bit3 fifo_empty (RO).
    - bit4 fifo_full (RO).
    - bit5 flush (WO, self-clearing): empties the FIFO, invalidates the pending event, state->LOAD.
    - bits[24:16] FIFO level (RO).
  - 0x08 CNT_HI:
    - R: returns counter[47:32] zero-extended, and latches counter[31:0] into a shadow register in the same cycle.
    - W: stages wdat[15:0].
  - 0x0C CNT_LO:
    - R: returns the shadow.
    - W: counter<={staged_hi, wdat}, taking effect next cycle (overrides increment).
  - 0x10 EV_HI W: stages event[63:32] (pattern in [31:16], timestamp[47:32] in [15:0]).
  - 0x14 EV_LO W: event[31:0]=wdat; pushes {staged_hi, wdat}.
    - If the FIFO is full, the push is dropped and overflow=1.
    - The staging register is kept, so repeated EV_LO writes reuse the same high word.
- Counter: 48-bit; increments by 1 each cycle while run=1; holds while run=0; wraps 2^48-1 -> 0 silently.
- State machine:
  - IDLE: entered from reset. Moves to LOAD when run=1.
  - LOAD: if the FIFO is non-empty, pop the head into the pending register and go to ARMED next cycle (pop-to-ARMED latency 1). If empty, remain in LOAD.
  - ARMED: on any edge where run=1 and counter >= pending.ts:
    - IO <= pending.pattern.
    - If counter > pending.ts, late=1.
    - Go to LOAD.
  - While run=0, ARMED and LOAD hold; no pops, no fires. Clearing run never changes IO.
  - Back-to-back events with equal or past timestamps therefore fire on successive firing edges, one event per two cycles (LOAD+ARMED); each such event after the first sets late if its comparison is strict.
- Comparison is unsigned over 48 bits; no wrap-aware compare.
- Simultaneous cases:
  - A push and a pop in the same cycle are both honoured; the level is unchanged.
  - A push into a full FIFO coinciding with a pop succeeds (space frees the same cycle).
  - A counter write in the cycle a fire is evaluated: the compare uses the pre-write counter.
  - Flush during ARMED: the pending event is discarded and IO is unchanged.
  - Reset mid-operation: full reset as above; no partial fire.

Test Plan:
- Reset with IO driven to 0x00FF via 0x00 (run=0) -> IO=0, STATUS=0x00000008 (empty, level 0), counter reads 0/0.
- Push events {0x0001,ts=10}, {0x0002,ts=20}, {0x0003,ts=20}, counter=0, set run -> IO=1 on edge with counter==10, IO=2 at counter==20, IO=3 at counter==22, late=1 (third event late).
- Push DEPTH+1 events with run=0 -> fifo_full=1, overflow=1, level=DEPTH; W1C 0x4 to STATUS clears overflow only.
- Arm event ts=100, clear run at counter=50, wait 200 cycles, set run -> IO changes exactly 50 running cycles later; no late.
- Write counter 0xFFFF_FFFFFFFE via CNT_HI/CNT_LO, run 3 cycles -> CNT_HI read 0, CNT_LO read 1 (wrap); CNT_LO shadow matches the CNT_HI read instant, not the later value.
- Flush with 3 events queued and one ARMED -> level 0, empty=1, IO unchanged; a new push with ts below counter fires within 2 cycles with late=1.

Source files
------------

// File: rtl/icosoc_mod_eventplay.sv
// rtl/icosoc_mod_eventplay.sv - timestamped event player peripheral for the icosoc ctrl bus
//
// icosoc_mod_eventplay_fifo: 64-bit event queue, DEPTH entries, single clock.
//   clk, reset         sync active-high reset
//   flush              empties the queue (wins over push/pop)
//   push, push_data    enqueue one event (caller guarantees space)
//   pop, head          dequeue; head is the current front entry
//   empty, full, level occupancy
//
// icosoc_mod_eventplay: top level.
//   clk, reset         sole clock, sync active-high reset
//   ctrl_wr/ctrl_rd    byte write strobes / read request
//   ctrl_addr/wdat     register byte address / write data
//   ctrl_rdat/done     registered read data and one-cycle acknowledge
//   IO                 registered output pattern

module icosoc_mod_eventplay_fifo #(
    parameter int DEPTH = 64,
    parameter int AW    = 6
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        push,
    input  logic [63:0] push_data,
    input  logic        pop,
    output logic [63:0] head,
    output logic        empty,
    output logic        full,
    output logic [AW:0] level
);
    localparam logic [AW:0] PTR_ONE    = {{AW{1'b0}}, 1'b1};
    localparam logic [AW:0] FULL_LEVEL = {1'b1, {AW{1'b0}}};

    logic [63:0] mem_q [DEPTH];
    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (flush) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (push) wptr_d = wptr_q + PTR_ONE;
            if (pop)  rptr_d = rptr_q + PTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // When full, a push that coincides with a pop lands in the slot being
    // vacated; head is read before the edge, so the popped value is the old one.
    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wptr_q[AW-1:0]] <= push_data;
    end

    assign head  = mem_q[rptr_q[AW-1:0]];
    assign level = wptr_q - rptr_q;
    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
endmodule

module icosoc_mod_eventplay #(
    parameter int IO_LENGTH     = 16,
    parameter int DEPTH         = 64,
    parameter int CLOCK_FREQ_HZ = 0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [3:0]           ctrl_wr,
    input  logic                 ctrl_rd,
    input  logic [15:0]          ctrl_addr,
    input  logic [31:0]          ctrl_wdat,
    output logic [31:0]          ctrl_rdat,
    output logic                 ctrl_done,
    output logic [IO_LENGTH-1:0] IO
);
    localparam int AW = $clog2(DEPTH);

    localparam logic [15:0] ADDR_IO     = 16'h0000;
    localparam logic [15:0] ADDR_STATUS = 16'h0004;
    localparam logic [15:0] ADDR_CNT_HI = 16'h0008;
    localparam logic [15:0] ADDR_CNT_LO = 16'h000C;
    localparam logic [15:0] ADDR_EV_HI  = 16'h0010;
    localparam logic [15:0] ADDR_EV_LO  = 16'h0014;

    if (IO_LENGTH < 1 || IO_LENGTH > 16 || DEPTH < 4 || DEPTH > 256 ||
        (DEPTH & (DEPTH - 1)) != 0 || CLOCK_FREQ_HZ < 0) begin : g_param_check
        $error("icosoc_mod_eventplay: unsupported parameter set");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_ARMED = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic                 done_q, done_d;
    logic [31:0]          rdat_q, rdat_d;
    logic [IO_LENGTH-1:0] io_q, io_d;
    logic                 run_q, run_d;
    logic                 late_q, late_d;
    logic                 ovf_q, ovf_d;
    logic [47:0]          cnt_q, cnt_d;
    logic [31:0]          shadow_q, shadow_d;
    logic [15:0]          cnt_hi_stage_q, cnt_hi_stage_d;
    logic [31:0]          ev_hi_q, ev_hi_d;
    logic [63:0]          pend_q, pend_d;
    logic                 pend_valid_q, pend_valid_d;

    logic        bus_req, bus_wr, bus_rd;
    logic        flush, push_req, push_ok, fifo_pop, fire;
    logic [63:0] fifo_head;
    logic        fifo_empty, fifo_full;
    logic [AW:0] fifo_level;

    // A new request is only taken while no acknowledge is showing, which
    // guarantees at least one idle cycle between acknowledges.
    assign bus_req  = !done_q && ((|ctrl_wr) || ctrl_rd);
    assign bus_wr   = bus_req && (|ctrl_wr);
    assign bus_rd   = bus_req && ctrl_rd;

    assign flush    = bus_wr && (ctrl_addr == ADDR_STATUS) && ctrl_wdat[5];
    assign push_req = bus_wr && (ctrl_addr == ADDR_EV_LO);
    assign fifo_pop = (state_q == ST_LOAD) && run_q && !fifo_empty && !flush;
    assign push_ok  = push_req && (!fifo_full || fifo_pop);
    // The compare uses the counter as it stands before this edge, so a
    // simultaneous counter write does not influence the decision.
    assign fire     = (state_q == ST_ARMED) && run_q && pend_valid_q &&
                      (cnt_q >= pend_q[47:0]) && !flush;

    icosoc_mod_eventplay_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .push      (push_ok),
        .push_data ({ev_hi_q, ctrl_wdat}),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .level     (fifo_level)
    );

    always_comb begin
        done_d         = bus_req;
        rdat_d         = '0;
        io_d           = io_q;
        run_d          = run_q;
        late_d         = late_q;
        ovf_d          = ovf_q;
        cnt_d          = run_q ? cnt_q + 48'd1 : cnt_q;
        shadow_d       = shadow_q;
        cnt_hi_stage_d = cnt_hi_stage_q;
        ev_hi_d        = ev_hi_q;
        pend_d         = pend_q;
        pend_valid_d   = pend_valid_q;
        state_d        = state_q;

        if (bus_rd) begin
            case (ctrl_addr)
                ADDR_IO:     rdat_d = 32'(io_q);
                ADDR_STATUS: rdat_d = {7'd0, 9'(fifo_level), 11'd0, fifo_full,
                                       fifo_empty, ovf_q, late_q, run_q};
                ADDR_CNT_HI: rdat_d = {16'd0, cnt_q[47:32]};
                ADDR_CNT_LO: rdat_d = shadow_q;
                default:     rdat_d = '0;
            endcase
            // Snapshot the low word so a later CNT_LO read is coherent with this one.
            if (ctrl_addr == ADDR_CNT_HI) shadow_d = cnt_q[31:0];
        end

        if (bus_wr) begin
            if (ctrl_addr == ADDR_IO && !run_q) io_d = ctrl_wdat[IO_LENGTH-1:0];
            if (ctrl_addr == ADDR_STATUS) begin
                run_d = ctrl_wdat[0];
                if (ctrl_wdat[1]) late_d = 1'b0;
                if (ctrl_wdat[2]) ovf_d  = 1'b0;
            end
            if (ctrl_addr == ADDR_CNT_HI) cnt_hi_stage_d = ctrl_wdat[15:0];
            if (ctrl_addr == ADDR_CNT_LO) cnt_d = {cnt_hi_stage_q, ctrl_wdat};
            if (ctrl_addr == ADDR_EV_HI)  ev_hi_d = ctrl_wdat;
        end

        if (push_req && !push_ok) ovf_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (run_q) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (fifo_pop) begin
                    pend_d       = fifo_head;
                    pend_valid_d = 1'b1;
                    state_d      = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (fire) begin
                    io_d         = pend_q[48 +: IO_LENGTH];
                    pend_valid_d = 1'b0;
                    state_d      = ST_LOAD;
                    if (cnt_q > pend_q[47:0]) late_d = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (flush) begin
            pend_valid_d = 1'b0;
            state_d      = ST_LOAD;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            done_q         <= 1'b0;
            rdat_q         <= '0;
            io_q           <= '0;
            run_q          <= 1'b0;
            late_q         <= 1'b0;
            ovf_q          <= 1'b0;
            cnt_q          <= '0;
            shadow_q       <= '0;
            cnt_hi_stage_q <= '0;
            ev_hi_q        <= '0;
            pend_q         <= '0;
            pend_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            done_q         <= done_d;
            rdat_q         <= rdat_d;
            io_q           <= io_d;
            run_q          <= run_d;
            late_q         <= late_d;
            ovf_q          <= ovf_d;
            cnt_q          <= cnt_d;
            shadow_q       <= shadow_d;
            cnt_hi_stage_q <= cnt_hi_stage_d;
            ev_hi_q        <= ev_hi_d;
            pend_q         <= pend_d;
            pend_valid_q   <= pend_valid_d;
        end
    end

    assign ctrl_done = done_q;
    assign ctrl_rdat = rdat_q;
    assign IO        = io_q;
endmodule

// File: tb/tb_icosoc_mod_eventplay.sv
// tb/tb_icosoc_mod_eventplay.sv - directed self-checking bench for icosoc_mod_eventplay

module tb_icosoc_mod_eventplay;
    localparam int IO_LENGTH = 16;
    localparam int DEPTH     = 64;

    localparam logic [15:0] A_IO = 16'h0000;
    localparam logic [15:0] A_ST = 16'h0004;
    localparam logic [15:0] A_CH = 16'h0008;
    localparam logic [15:0] A_CL = 16'h000C;
    localparam logic [15:0] A_EH = 16'h0010;
    localparam logic [15:0] A_EL = 16'h0014;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [3:0]           ctrl_wr;
    logic                 ctrl_rd;
    logic [15:0]          ctrl_addr;
    logic [31:0]          ctrl_wdat;
    logic [31:0]          ctrl_rdat;
    logic                 ctrl_done;
    logic [IO_LENGTH-1:0] io;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    icosoc_mod_eventplay #(
        .IO_LENGTH     (IO_LENGTH),
        .DEPTH         (DEPTH),
        .CLOCK_FREQ_HZ (0)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ctrl_wr   (ctrl_wr),
        .ctrl_rd   (ctrl_rd),
        .ctrl_addr (ctrl_addr),
        .ctrl_wdat (ctrl_wdat),
        .ctrl_rdat (ctrl_rdat),
        .ctrl_done (ctrl_done),
        .IO        (io)
    );

    task automatic chk(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        @(negedge clk);
        ctrl_wr   = 4'hF;
        ctrl_addr = addr;
        ctrl_wdat = data;
        @(negedge clk);
        ctrl_wr   = 4'h0;
    endtask

    task automatic rd_chk(input string tag, input logic [15:0] addr, input logic [31:0] expected);
        logic [31:0] data;
        @(negedge clk);
        ctrl_rd   = 1'b1;
        ctrl_addr = addr;
        @(negedge clk);
        data = ctrl_rdat;
        chk({tag, "_done"}, 32'(ctrl_done), 32'd1);
        ctrl_rd = 1'b0;
        chk(tag, data, expected);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] exp_io;
        reset     = 1'b1;
        ctrl_wr   = 4'h0;
        ctrl_rd   = 1'b0;
        ctrl_addr = 16'h0;
        ctrl_wdat = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;

        // Reset behaviour with IO previously driven
        bus_write(A_IO, 32'h0000_00FF);
        rd_chk("io_rd_pre_reset", A_IO, 32'h0000_00FF);
        chk("io_pin_pre_reset", 32'(io), 32'h0000_00FF);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("reset_io", 32'(io), 32'h0);
        chk("reset_done", 32'(ctrl_done), 32'h0);
        chk("reset_rdat", ctrl_rdat, 32'h0);
        rd_chk("reset_status", A_ST, 32'h0000_0008);
        rd_chk("reset_cnt_hi", A_CH, 32'h0);
        rd_chk("reset_cnt_lo", A_CL, 32'h0);
        rd_chk("unmapped_rd", 16'h0018, 32'h0);

        // Three events: ts 10, 20, 20 (third fires late)
        bus_write(A_EH, 32'h0001_0000);
        bus_write(A_EL, 32'd10);
        bus_write(A_EH, 32'h0002_0000);
        bus_write(A_EL, 32'd20);
        bus_write(A_EH, 32'h0003_0000);
        bus_write(A_EL, 32'd20);
        bus_write(A_CH, 32'h0);
        bus_write(A_CL, 32'h0);
        bus_write(A_ST, 32'h1);
        for (int k = 1; k <= 25; k++) begin
            @(negedge clk);
            exp_io = (k <= 10) ? 32'd0 : (k <= 20) ? 32'd1 : (k <= 22) ? 32'd2 : 32'd3;
            chk($sformatf("seq_io_k%0d", k), 32'(io), exp_io);
        end
        rd_chk("seq_status_late", A_ST, 32'h0000_000B);

        // Overflow: DEPTH+1 pushes with run=0
        bus_write(A_ST, 32'h2);
        rd_chk("late_w1c", A_ST, 32'h0000_0008);
        bus_write(A_EH, 32'h0010_0000);
        for (int i = 0; i < DEPTH + 1; i++) bus_write(A_EL, 32'(1000 + i));
        rd_chk("ovf_status", A_ST, 32'h0040_0014);
        bus_write(A_ST, 32'h4);
        rd_chk("ovf_w1c", A_ST, 32'h0040_0010);
        bus_write(A_ST, 32'h20);
        rd_chk("flush_status", A_ST, 32'h0000_0008);
        chk("flush_io", 32'(io), 32'h3);

        // Pause while armed: ts=100, stop at counter 50, resume later
        bus_write(A_CH, 32'h0);
        bus_write(A_CL, 32'h0);
        bus_write(A_EH, 32'h00AA_0000);
        bus_write(A_EL, 32'd100);
        bus_write(A_ST, 32'h1);
        repeat (48) @(negedge clk);
        bus_write(A_ST, 32'h0);
        rd_chk("pause_cnt_hi", A_CH, 32'h0);
        rd_chk("pause_cnt_lo", A_CL, 32'd50);
        chk("pause_io", 32'(io), 32'h3);
        repeat (200) @(negedge clk);
        chk("pause_io_held", 32'(io), 32'h3);
        bus_write(A_ST, 32'h1);
        repeat (50) @(negedge clk);
        chk("resume_io_k50", 32'(io), 32'h3);
        @(negedge clk);
        chk("resume_io_k51", 32'(io), 32'h00AA);
        rd_chk("resume_status", A_ST, 32'h0000_0009);

        // Counter wrap and shadow coherence
        bus_write(A_ST, 32'h0);
        bus_write(A_CH, 32'h0000_FFFF);
        bus_write(A_CL, 32'hFFFF_FFFE);
        rd_chk("wr_cnt_hi", A_CH, 32'h0000_FFFF);
        rd_chk("wr_cnt_lo", A_CL, 32'hFFFF_FFFE);
        bus_write(A_ST, 32'h1);
        @(negedge clk);
        bus_write(A_ST, 32'h0);
        rd_chk("wrap_cnt_hi", A_CH, 32'h0);
        rd_chk("wrap_cnt_lo", A_CL, 32'h1);
        bus_write(A_ST, 32'h1);
        rd_chk("snap_cnt_hi", A_CH, 32'h0);
        repeat (5) @(negedge clk);
        rd_chk("snap_cnt_lo", A_CL, 32'h2);

        // Flush with one armed and three queued, then a late push
        bus_write(A_EH, 32'h0055_0001);
        repeat (4) bus_write(A_EL, 32'h0);
        bus_write(A_IO, 32'h0000_1234);
        rd_chk("armed_status", A_ST, 32'h0003_0001);
        chk("io_write_ignored_run", 32'(io), 32'h00AA);
        bus_write(A_ST, 32'h21);
        rd_chk("flush_armed_status", A_ST, 32'h0000_0009);
        chk("flush_armed_io", 32'(io), 32'h00AA);
        bus_write(A_EH, 32'h0077_0000);
        bus_write(A_EL, 32'd5);
        @(negedge clk);
        chk("late_push_k1", 32'(io), 32'h00AA);
        @(negedge clk);
        chk("late_push_k2", 32'(io), 32'h0077);
        rd_chk("late_push_status", A_ST, 32'h0000_000B);

        // Reset mid-operation
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("midrun_reset_io", 32'(io), 32'h0);
        rd_chk("midrun_reset_status", A_ST, 32'h0000_0008);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
